// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: default widths,
// the loader state encoding and the legal image-length check.
// Imported by the loader, its byte packer and the testbench.
package imem_loader_pkg;

  localparam int IMEM_ADDR_WIDTH = 6;
  localparam int IMEM_DATA_WIDTH = 32;
  localparam int MAX_WORDS       = 2 ** IMEM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_COLLECT = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // A length byte is legal when it names at least one word and no more
  // words than the memory holds.
  function automatic logic len_legal(input logic [7:0] len, input int unsigned max_words);
    return (len != 8'd0) && (32'(len) <= max_words);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer
// Assembles a little-endian word from a byte stream. Byte k of a word lands
// in lane k (bits [8k+7:8k]).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         restart at lane 0 (new load)
//   accept        a byte is transferred this cycle
//   byte_in       byte being transferred
//   word_full     accept of the last lane of a word (combinational)
//   word_next     word including the byte accepted this cycle, so the
//                 caller can register it on the same edge as the last byte
module imem_loader_byte_packer #(
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        accept,
  input  logic [7:0]                  byte_in,
  output logic                        word_full,
  output logic [8*BYTES_PER_WORD-1:0] word_next
);

  localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_WORD - 1);

  logic [IW-1:0] byte_idx_q, byte_idx_d;

  assign word_full = accept && (byte_idx_q == LAST_IDX);

  always_comb begin
    byte_idx_d = byte_idx_q;
    if (clear) begin
      byte_idx_d = '0;
    end else if (accept) begin
      byte_idx_d = word_full ? '0 : byte_idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
    end
  end

  // One holding register per byte lane.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic [7:0] lane_q, lane_d;

      always_comb begin
        lane_d = lane_q;
        if (accept && (byte_idx_q == IW'(gi))) begin
          lane_d = byte_in;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_q <= 8'd0;
        end else begin
          lane_q <= lane_d;
        end
      end

      assign word_next[8*gi +: 8] = lane_d;
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Streams a program image into instruction memory and holds the core
// stopped until the image is complete. The stream is a length byte (number
// of words, 1..2**ADDR_WIDTH) followed by the instruction bytes,
// little-endian within each word. Words go to consecutive addresses from 0.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        pulse to begin a load (honoured in IDLE and DONE only)
//   in_valid     byte source has in_data valid
//   in_data      byte stream
//   in_ready     loader accepts a byte this cycle (registered)
//   imem_we      one-cycle write strobe per word
//   imem_addr    write word address
//   imem_wdata   assembled word
//   busy         load in progress
//   done         image fully written
//   error        sticky illegal-length flag, cleared by an accepted start
//   cpu_run      core may advance its PC (only once the image is written)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = IMEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_run
);

  localparam int          BYTES_PER_WORD = DATA_WIDTH / 8;
  // Word count needs one extra bit to hold the full depth.
  localparam int          CW             = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH          = 2 ** ADDR_WIDTH;

  state_e                  state_q, state_d;
  logic [CW-1:0]           word_count_q, word_count_d;
  logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
  logic                    error_q, error_d;
  logic                    in_ready_q, in_ready_d;
  logic                    imem_we_q, imem_we_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cpu_run_q, cpu_run_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0]   imem_wdata_q, imem_wdata_d;

  logic                    handshake;
  logic                    collect_accept;
  logic                    start_accept;
  logic                    last_word;
  logic                    word_full;
  logic [DATA_WIDTH-1:0]   word_next;

  assign handshake      = in_valid && in_ready_q;
  assign collect_accept = handshake && (state_q == ST_COLLECT);
  assign last_word      = ({1'b0, word_idx_q} == (word_count_q - CW'(1)));

  imem_loader_byte_packer #(
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_accept),
    .accept   (collect_accept),
    .byte_in  (in_data),
    .word_full(word_full),
    .word_next(word_next)
  );

  // Next-state logic and datapath updates.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    word_idx_d   = word_idx_q;
    error_d      = error_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    start_accept = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_LEN;
          error_d      = 1'b0;
          word_idx_d   = '0;
          start_accept = 1'b1;
        end
      end
      ST_LEN: begin
        if (handshake) begin
          if (len_legal(in_data, DEPTH)) begin
            word_count_d = CW'(in_data);
            state_d      = ST_COLLECT;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_COLLECT: begin
        // Capture address and word on the last byte so both are stable
        // for the whole WRITE cycle.
        if (word_full) begin
          state_d      = ST_WRITE;
          imem_addr_d  = word_idx_q;
          imem_wdata_d = word_next;
        end
      end
      ST_WRITE: begin
        if (last_word) begin
          state_d = ST_DONE;
        end else begin
          word_idx_d = word_idx_q + ADDR_WIDTH'(1);
          state_d    = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one is
  // valid for exactly the cycles spent in the corresponding state.
  always_comb begin
    in_ready_d = (state_d == ST_LEN) || (state_d == ST_COLLECT);
    imem_we_d  = (state_d == ST_WRITE);
    busy_d     = (state_d == ST_LEN) || (state_d == ST_COLLECT) || (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
    cpu_run_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      word_idx_q   <= '0;
      error_q      <= 1'b0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_run_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      word_idx_q   <= word_idx_d;
      error_q      <= error_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_run_q    <= cpu_run_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_run    = cpu_run_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_run;

  int total = 0;
  int bad   = 0;

  // Write log filled by the monitor.
  int          wr_total = 0;
  int          wr_ready_bad = 0;
  logic [5:0]  wr_addr [256];
  logic [31:0] wr_data [256];

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_run   (cpu_run)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && imem_we) begin
      wr_addr[wr_total % 256] = imem_addr;
      wr_data[wr_total % 256] = imem_wdata;
      if (in_ready) wr_ready_bad++;
      $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
      wr_total++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check_eq("hs_timeout", {63'd0, in_ready}, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check_eq("wait_done", {63'd0, done}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] full_word(input int i);
    return {8'(i), 8'h5A, 8'(255 - i), 8'(i + 1)};
  endfunction

  logic [31:0] tri_words [3];
  int base;
  int errs;

  initial begin
    tri_words[0] = 32'h11223344;
    tri_words[1] = 32'hDEADBEEF;
    tri_words[2] = 32'h00000093;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_flags", {58'd0, in_ready, imem_we, busy, done, error, cpu_run}, 64'd0);
    check_eq("reset_addr", {58'd0, imem_addr}, 64'd0);
    check_eq("reset_wdata", {32'd0, imem_wdata}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word at full rate.
    base = wr_total;
    pulse_start();
    check_eq("len_busy_ready", {62'd0, busy, in_ready}, 64'd3);
    send_byte(8'h01);
    send_byte(8'h13);
    send_byte(8'h05);
    send_byte(8'h10);
    send_byte(8'h00);
    check_eq("w1_we", {63'd0, imem_we}, 64'd1);
    check_eq("w1_addr", {58'd0, imem_addr}, 64'd0);
    check_eq("w1_wdata", {32'd0, imem_wdata}, 64'h00100513);
    check_eq("w1_ready_low", {63'd0, in_ready}, 64'd0);
    check_eq("w1_cpu_run_before", {63'd0, cpu_run}, 64'd0);
    @(posedge clk);
    #1;
    check_eq("w1_done_run", {61'd0, done, cpu_run, imem_we}, 64'd6);
    check_eq("w1_count", 64'(wr_total - base), 64'd1);

    // Three words, in_valid toggling every other cycle.
    base = wr_total;
    pulse_start();
    send_byte(8'h03);
    @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) send_word(tri_words[w], 1'b1);
    wait_done();
    check_eq("tri_count", 64'(wr_total - base), 64'd3);
    for (int w = 0; w < 3; w++) begin
      check_eq("tri_addr", {58'd0, wr_addr[(base + w) % 256]}, 64'(w));
      check_eq("tri_data", {32'd0, wr_data[(base + w) % 256]}, {32'd0, tri_words[w]});
    end

    // Illegal lengths.
    base = wr_total;
    pulse_start();
    send_byte(8'h00);
    check_eq("len0_err_idle", {61'd0, error, busy, in_ready}, 64'd4);
    pulse_start();
    check_eq("err_cleared", {63'd0, error}, 64'd0);
    send_byte(8'h41);
    check_eq("len41_err_idle", {61'd0, error, busy, in_ready}, 64'd4);
    repeat (3) @(posedge clk);
    #1;
    check_eq("err_sticky", {63'd0, error}, 64'd1);
    check_eq("illegal_writes", 64'(wr_total - base), 64'd0);

    // Full depth: 64 words.
    base = wr_total;
    pulse_start();
    check_eq("full_err_cleared", {63'd0, error}, 64'd0);
    send_byte(8'h40);
    for (int w = 0; w < 64; w++) send_word(full_word(w), 1'b0);
    wait_done();
    check_eq("full_count", 64'(wr_total - base), 64'd64);
    check_eq("full_last_addr", {58'd0, wr_addr[(base + 63) % 256]}, 64'd63);
    errs = 0;
    for (int w = 0; w < 64; w++) begin
      if (wr_data[(base + w) % 256] !== full_word(w) || wr_addr[(base + w) % 256] !== 6'(w)) errs++;
    end
    check_eq("full_data_errs", 64'(errs), 64'd0);

    // Async reset after byte 2 of word 5.
    base = wr_total;
    pulse_start();
    send_byte(8'h08);
    for (int w = 0; w < 4; w++) send_word(full_word(w + 10), 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_flags", {58'd0, in_ready, imem_we, busy, done, error, cpu_run}, 64'd0);
    check_eq("arst_addr", {58'd0, imem_addr}, 64'd0);
    check_eq("arst_wdata", {32'd0, imem_wdata}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("arst_writes", 64'(wr_total - base), 64'd4);
    base = wr_total;
    pulse_start();
    send_byte(8'h01);
    send_word(32'hCAFEF00D, 1'b0);
    wait_done();
    check_eq("reload_count", 64'(wr_total - base), 64'd1);
    check_eq("reload_addr", {58'd0, wr_addr[base % 256]}, 64'd0);
    check_eq("reload_data", {32'd0, wr_data[base % 256]}, 64'hCAFEF00D);

    // Start while busy is ignored.
    base = wr_total;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h78);
    send_byte(8'h56);
    pulse_start();
    check_eq("busy_start_ignored", {62'd0, busy, in_ready}, 64'd3);
    send_byte(8'h34);
    send_byte(8'h12);
    send_word(32'h87654321, 1'b0);
    wait_done();
    check_eq("busy_start_count", 64'(wr_total - base), 64'd2);
    check_eq("busy_start_d0", {32'd0, wr_data[base % 256]}, 64'h12345678);
    check_eq("busy_start_a1", {58'd0, wr_addr[(base + 1) % 256]}, 64'd1);
    check_eq("busy_start_d1", {32'd0, wr_data[(base + 1) % 256]}, 64'h87654321);

    // Restart from DONE.
    check_eq("pre_restart_run", {62'd0, done, cpu_run}, 64'd3);
    base = wr_total;
    pulse_start();
    check_eq("restart_run_low", {61'd0, done, cpu_run, busy}, 64'd1);
    send_byte(8'h01);
    send_word(32'h0000006F, 1'b0);
    wait_done();
    check_eq("restart_count", 64'(wr_total - base), 64'd1);
    check_eq("restart_addr", {58'd0, wr_addr[base % 256]}, 64'd0);
    check_eq("restart_data", {32'd0, wr_data[base % 256]}, 64'h0000006F);

    check_eq("ready_in_write", 64'(wr_ready_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: streams a program image into instruction memory before the single-cycle core fetches from it.
- Accepts bytes over a valid/ready handshake and assembles them little-endian into 32-bit words.
- Writes each word to consecutive 6-bit word addresses.
- Holds the core stopped (cpu_run low) until the whole image is written.

Parameters:
- ADDR_WIDTH, 6, instruction memory word-address width (depth = 2**ADDR_WIDTH = 64).
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8.
- BYTES_PER_WORD, DATA_WIDTH/8 (= 4), bytes per word; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; ignored while busy.
- in_valid  input  1  byte source has in_data valid.
- in_data  input  8  byte stream: length byte first, then instruction bytes.
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  DATA_WIDTH  assembled instruction word.
- busy  output  1  high in LEN, COLLECT, WRITE.
- done  output  1  high in DONE.
- error  output  1  sticky illegal-length flag; cleared by the next accepted start.
- cpu_run  output  1  enables PC advance in the top level; high only in DONE.

Behaviour:
- All outputs are registered or decoded from registered state; no combinational path from in_valid to in_ready.
- Reset (async, any state): state=IDLE; in_ready, imem_we, busy, done, error, cpu_run = 0; imem_addr=0; imem_wdata=0; byte/word counters 0. Words already written stay in memory; a partial word is never written.
- States:
  - IDLE: in_ready=0. start -> LEN (error cleared).
  - LEN: in_ready=1. On handshake, L=in_data. L in 1..64 -> word_count=L, COLLECT. L=0 or L>64 -> error=1, IDLE.
  - COLLECT: in_ready=1. Each handshake stores in_data at byte lane byte_idx (first byte -> [7:0], fourth -> [31:24]) and increments byte_idx. Handshake with byte_idx=3 -> byte_idx=0, WRITE.
  - WRITE: in_ready=0; imem_we=1 for exactly this cycle; imem_addr=word_idx; imem_wdata=assembled word. If word_idx==word_count-1 -> DONE; else word_idx+1 -> COLLECT.
  - DONE: done=1, cpu_run=1, in_ready=0. start -> LEN; done and cpu_run drop the next cycle and word_idx resets to 0.
- Latency: the 4th byte accepted at edge N produces imem_we high during cycle N+1. done/cpu_run rise the cycle after the final write.
- in_valid low during COLLECT: loader stalls indefinitely with no timeout; partial-word state is held.
- start while busy: ignored, no restart. start in IDLE and DONE: accepted.
- word_idx never wraps: L=64 ends at address 63.
- Bytes offered outside LEN/COLLECT are not consumed (in_ready=0).
- Throughput: at most one byte per cycle; 5 cycles per word at full rate (4 accept + 1 write).

Decomposition:
- Shared package: state encoding constants (IDLE, LEN, COLLECT, WRITE, DONE) and the maximum word count (2**ADDR_WIDTH), reused by the top-level integration and the bench.
- One natural sub-module, byte_packer: byte-lane shift/assemble register with byte_idx and a word_full output.
- The FSM and address counter stay in imem_loader.

Test Plan:
- Single word: start; bytes 0x01, 0x13, 0x05, 0x10, 0x00 at full rate -> one imem_we pulse with addr=0, wdata=0x00100513; done=1 and cpu_run=1 on the following cycle.
- Three words with in_valid toggling every other cycle: length 0x03, then 12 bytes -> writes at addr 0, 1, 2 with correct little-endian words; exactly 3 imem_we pulses; in_ready low during each WRITE.
- Illegal lengths: length 0x00, then separately 0x41 -> error=1, back in IDLE, zero writes. The next start clears error.
- Full depth: length 0x40 and 256 bytes -> 64 writes, last at addr 63, no wrap, done asserted.
- Async reset after byte 2 of word 5: rst pulsed mid-cycle -> all outputs 0 immediately, no write for word 5; reload from start works.
- Restart from DONE and start during busy: start pulse while in COLLECT is ignored (word count unchanged). start in DONE -> cpu_run low next cycle, new load writes from addr 0.
